// File: rtl/weight_load_pkg.sv
// Shared constants and state encoding for the kernel weight loader.
// CKSUM_W sizes the optional checksum enabled by WEIGHT_CKSUM_EN.
package weight_load_pkg;
   localparam int NUM_W   = 25;
   localparam int DATA_W  = 8;
   localparam int ADDR_W  = 5;
   localparam int KSEL_W  = 2;
   localparam int ROM_AW  = 7;
   localparam int CKSUM_W = $clog2(NUM_W * 255 + 1);

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DRAIN
   } state_t;
endpackage

// File: rtl/weight_load_ctrl_if.sv
// ROM read / bank write / status bundle of the weight loader.
// oCksum exists only when WEIGHT_CKSUM_EN is defined.
interface weight_load_ctrl_if;
   import weight_load_pkg::*;

   logic                iStart;
   logic                iAbort;
   logic [KSEL_W-1:0]   iKernelSel;
   logic [ROM_AW-1:0]   oRomAddr;
   logic [DATA_W-1:0]   iRomData;
   logic                oWren;
   logic [ADDR_W-1:0]   oAddr;
   logic [DATA_W-1:0]   oWeight;
   logic                oBusy;
   logic                oDone;
   logic                oLoadedValid;
   logic [KSEL_W-1:0]   oLoadedSel;
`ifdef WEIGHT_CKSUM_EN
   logic [CKSUM_W-1:0]  oCksum;
`endif

   modport master (
      input  iStart, iAbort, iKernelSel, iRomData,
      output oRomAddr, oWren, oAddr, oWeight,
      output oBusy, oDone, oLoadedValid, oLoadedSel
`ifdef WEIGHT_CKSUM_EN
      , output oCksum
`endif
   );

   modport slave (
      output iStart, iAbort, iKernelSel, iRomData,
      input  oRomAddr, oWren, oAddr, oWeight,
      input  oBusy, oDone, oLoadedValid, oLoadedSel
`ifdef WEIGHT_CKSUM_EN
      , input oCksum
`endif
   );
endinterface

// File: rtl/weight_cksum.sv
// Running unsigned sum of written weights; cleared on load start.
// Only instantiated when WEIGHT_CKSUM_EN is defined.
module weight_cksum
   import weight_load_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr,
   input  logic               acc,
   input  logic [DATA_W-1:0]  din,
   output logic [CKSUM_W-1:0] sum
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sum <= '0;
      else if (clr)
         sum <= '0;
      else if (acc)
         sum <= sum + CKSUM_W'(din);
   end
endmodule

// File: rtl/weight_load_ctrl.sv
// Copies one 25-weight kernel from a synchronous ROM into the weight bank.
// Define WEIGHT_CKSUM_EN to add the oCksum running-sum output.
module weight_load_ctrl
   import weight_load_pkg::*;
(
   input  logic               iCLK,
   input  logic               iRST,
   weight_load_ctrl_if.master bus
);
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_W - 1);

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [KSEL_W-1:0]   sel_q, sel_d;
   logic [ROM_AW-1:0]   rom_q, rom_d;
   logic                wren_q, wren_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                lv_q, lv_d;
   logic [KSEL_W-1:0]   ls_q, ls_d;
   logic [ROM_AW-1:0]   base;
   logic                go;

   assign base = ROM_AW'(bus.iKernelSel) * ROM_AW'(NUM_W);
   assign go   = (state_q == IDLE) && bus.iStart && !bus.iAbort;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      rom_d   = rom_q;
      wren_d  = wren_q;
      addr_d  = addr_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      lv_d    = lv_q;
      ls_d    = ls_q;
      unique case (state_q)
         IDLE: begin
            if (go) begin
               state_d = FETCH;
               cnt_d   = '0;
               sel_d   = bus.iKernelSel;
               rom_d   = base;
               busy_d  = 1'b1;
               lv_d    = 1'b0;
            end
         end
         FETCH: begin
            if (bus.iAbort) begin
               state_d = IDLE;
               wren_d  = 1'b0;
               busy_d  = 1'b0;
            end else begin
               // write trails the read by the ROM's one-cycle latency
               wren_d = 1'b1;
               addr_d = cnt_q;
               if (cnt_q == LAST) begin
                  state_d = DRAIN;
               end else begin
                  cnt_d = cnt_q + 1'b1;
                  rom_d = rom_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            state_d = IDLE;
            wren_d  = 1'b0;
            busy_d  = 1'b0;
            if (!bus.iAbort) begin
               done_d = 1'b1;
               lv_d   = 1'b1;
               ls_d   = sel_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         rom_q   <= '0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         lv_q    <= 1'b0;
         ls_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         rom_q   <= rom_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         lv_q    <= lv_d;
         ls_q    <= ls_d;
      end
   end

   assign bus.oRomAddr     = rom_q;
   assign bus.oWren        = wren_q;
   assign bus.oAddr        = addr_q;
   assign bus.oWeight      = bus.iRomData;
   assign bus.oBusy        = busy_q;
   assign bus.oDone        = done_q;
   assign bus.oLoadedValid = lv_q;
   assign bus.oLoadedSel   = ls_q;

`ifdef WEIGHT_CKSUM_EN
   weight_cksum u_cksum (
      .clk (iCLK),
      .rst (iRST),
      .clr (go),
      .acc (wren_q),
      .din (bus.iRomData),
      .sum (bus.oCksum)
   );
`endif
endmodule

// File: tb/tb_weight_load_ctrl.sv
// Bench for weight_load_ctrl: directed table, corner sequences, random run.
// Define WEIGHT_CKSUM_EN to also check oCksum.
module tb_weight_load_ctrl;
   import weight_load_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic chk_on = 1'b0;
   int   n_cmp = 0;
   int   n_err = 0;

   weight_load_ctrl_if bus();

   weight_load_ctrl dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [128];

   always @(posedge clk) bus.iRomData <= rom[bus.oRomAddr];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                  $time);
      end
   endtask

   // Transaction-level model: a load is "t edges since start"
   logic m_act, m_done, m_lv;
   int   m_t, m_sel, m_ls, m_rom;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_act <= 0; m_done <= 0; m_lv <= 0;
         m_t <= 0; m_sel <= 0; m_ls <= 0; m_rom <= 0;
      end else begin
         m_done <= 0;
         if (m_act) begin
            if (bus.iAbort) begin
               m_act <= 0;
            end else if (m_t == NUM_W) begin
               m_act <= 0; m_done <= 1; m_lv <= 1; m_ls <= m_sel;
            end else begin
               m_t <= m_t + 1;
               if (m_t + 1 <= NUM_W - 1)
                  m_rom <= m_sel * NUM_W + m_t + 1;
            end
         end else if (bus.iStart && !bus.iAbort) begin
            m_act <= 1; m_t <= 0; m_lv <= 0;
            m_sel <= int'(bus.iKernelSel);
            m_rom <= int'(bus.iKernelSel) * NUM_W;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on && !rst) begin
         chk("m_busy", bus.oBusy, m_act);
         chk("m_wren", bus.oWren, m_act && m_t >= 1);
         if (m_act && m_t >= 1) begin
            chk("m_addr", bus.oAddr, m_t - 1);
            chk("m_weight", bus.oWeight, rom[m_sel * NUM_W + m_t - 1]);
         end
         chk("m_romaddr", bus.oRomAddr, m_rom);
         chk("m_done", bus.oDone, m_done);
         chk("m_lvalid", bus.oLoadedValid, m_lv);
         if (m_lv) chk("m_lsel", bus.oLoadedSel, m_ls);
      end
   end

   typedef struct {
      int ksel; int rp1; int rp2; int ab;
      int writes; int dones; int lv; int ls; int rom0; int sum;
   } vec_t;

   vec_t tbl [4];

   task automatic wait_idle();
      int n = 0;
      while (bus.oBusy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (bus.oBusy) chk("idle_timeout", 1, 0);
   endtask

   task automatic run_load(input vec_t v);
      int nw = 0, nd = 0, sum = 0, first;
      bit hit;
      wait_idle();
      @(negedge clk);
      bus.iKernelSel = v.ksel[KSEL_W-1:0];
      bus.iStart = 1; bus.iAbort = 0;
      @(negedge clk);
      first = int'(bus.oRomAddr);
      for (int c = 0; c < 34; c++) begin
         if (c > 0) @(negedge clk);
         if (bus.oWren) begin nw++; sum += int'(bus.oWeight); end
         if (bus.oDone) nd++;
         hit = (c == v.rp1) || (c == v.rp2);
         bus.iStart = hit;
         bus.iKernelSel = hit ? 2'd2 : v.ksel[KSEL_W-1:0];
         bus.iAbort = (c == v.ab);
      end
      bus.iStart = 0; bus.iAbort = 0;
      chk("t_rom0", first, v.rom0);
      chk("t_writes", nw, v.writes);
      chk("t_dones", nd, v.dones);
      chk("t_lvalid", bus.oLoadedValid, v.lv);
      if (v.lv != 0) chk("t_lsel", bus.oLoadedSel, v.ls);
      chk("t_busy_end", bus.oBusy, 0);
      chk("t_wsum", sum, v.sum);
`ifdef WEIGHT_CKSUM_EN
      chk("t_cksum", bus.oCksum, v.sum);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      for (int i = 0; i < 128; i++) rom[i] = 8'(i + 1);
      tbl[0] = '{0, -1, -1, -1, 25, 1, 1, 0, 0, 325};
      tbl[1] = '{3, -1, -1, -1, 25, 1, 1, 3, 75, 2200};
      tbl[2] = '{1, 5, 10, -1, 25, 1, 1, 1, 25, 950};
      tbl[3] = '{2, -1, -1, 12, 12, 0, 0, 0, 50, 678};

      bus.iStart = 0; bus.iAbort = 0; bus.iKernelSel = '0;
      #12;
      chk("rst_romaddr", bus.oRomAddr, 0);
      chk("rst_wren", bus.oWren, 0);
      chk("rst_addr", bus.oAddr, 0);
      chk("rst_busy", bus.oBusy, 0);
      chk("rst_done", bus.oDone, 0);
      chk("rst_lvalid", bus.oLoadedValid, 0);
      chk("rst_lsel", bus.oLoadedSel, 0);
`ifdef WEIGHT_CKSUM_EN
      chk("rst_cksum", bus.oCksum, 0);
`endif
      @(negedge clk);
      rst = 0;
      chk_on = 1;

      for (int i = 0; i < 4; i++) run_load(tbl[i]);

      // start+abort together in IDLE: abort wins, loaded kernel kept
      run_load(tbl[1]);
      @(negedge clk);
      bus.iStart = 1; bus.iAbort = 1; bus.iKernelSel = 2'd0;
      @(negedge clk);
      bus.iStart = 0; bus.iAbort = 0;
      chk("ab_idle_busy", bus.oBusy, 0);
      chk("ab_idle_lvalid", bus.oLoadedValid, 1);
      chk("ab_idle_lsel", bus.oLoadedSel, 3);
      repeat (3) @(negedge clk);
      chk("ab_idle_wren", bus.oWren, 0);

      // back-to-back start in the done cycle
      @(negedge clk);
      bus.iStart = 1; bus.iKernelSel = 2'd0;
      @(negedge clk);
      bus.iStart = 0;
      n = 0;
      while (!bus.oDone && n < 40) begin @(negedge clk); n++; end
      chk("b2b_first_done", bus.oDone, 1);
      bus.iStart = 1; bus.iKernelSel = 2'd1;
      @(negedge clk);
      bus.iStart = 0;
      chk("b2b_rom0", bus.oRomAddr, 25);
      chk("b2b_busy", bus.oBusy, 1);
      n = 1;
      while (!bus.oDone && n < 40) begin @(negedge clk); n++; end
      chk("b2b_gap", n, 27);
      chk("b2b_lsel", bus.oLoadedSel, 1);

      // asynchronous reset in the middle of a load
      @(negedge clk);
      bus.iStart = 1; bus.iKernelSel = 2'd2;
      @(negedge clk);
      bus.iStart = 0;
      repeat (8) @(negedge clk);
      #2 rst = 1;
      #1;
      chk("arst_romaddr", bus.oRomAddr, 0);
      chk("arst_wren", bus.oWren, 0);
      chk("arst_addr", bus.oAddr, 0);
      chk("arst_busy", bus.oBusy, 0);
      chk("arst_lvalid", bus.oLoadedValid, 0);
      chk("arst_lsel", bus.oLoadedSel, 0);
      @(negedge clk);
      rst = 0;
      run_load(tbl[0]);

      // random traffic against the model
      for (int i = 0; i < 128; i++) rom[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         bus.iStart = ($urandom_range(0, 5) == 0);
         bus.iAbort = ($urandom_range(0, 39) == 0);
         bus.iKernelSel = KSEL_W'($urandom_range(0, 3));
      end
      @(negedge clk);
      bus.iStart = 0; bus.iAbort = 0;
      wait_idle();
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
               n_err);
      $finish;
   end
endmodule
